dsp_result_capture: RTL and testbench



---
 rtl/dsp_capture_pkg.sv | 31 +++
 rtl/dsp_result_capture_fifo.sv | 40 ++++
 rtl/dsp_result_capture.sv | 66 ++++++
 tb/tb_dsp_result_capture.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/dsp_capture_pkg.sv
// dsp_capture_pkg: shared constants, result entry type and round/saturate helper.
// DSP_CAPTURE_ROUND_EN selects round-half-up; otherwise results are floor-truncated.
package dsp_capture_pkg;
  localparam int P_W = 48;
  localparam int DEF_LATENCY = 4;
  localparam int DEF_SHIFT = 12;
  localparam int DEF_OUT_W = 24;
  localparam int DEF_DEPTH = 4;
  localparam logic signed [P_W:0] ONE = 1;
  // data is sized for the widest legal OUT_W; the low OUT_W bits hold the result
  typedef struct packed {
    logic [P_W-1:0] data;
    logic carry;
    logic sat;
  } cap_entry_t;
  function automatic cap_entry_t round_sat(input logic [P_W-1:0] p, input int shift, input int out_w);
    logic signed [P_W:0] x, mx, mn;
    cap_entry_t r;
    x = {p[P_W-1], p};
`ifdef DSP_CAPTURE_ROUND_EN
    if (shift > 0) x = x + (ONE <<< (shift - 1));
`endif
    x = x >>> shift;
    mx = (ONE <<< (out_w - 1)) - ONE;
    mn = -(ONE <<< (out_w - 1));
    r.carry = 1'b0;
    r.sat = x > mx || x < mn;
    r.data = x > mx ? mx[P_W-1:0] : x < mn ? mn[P_W-1:0] : x[P_W-1:0];
    return r;
  endfunction
endpackage

// File: rtl/dsp_result_capture_fifo.sv
// capture_fifo: DEPTH-entry synchronous FIFO of capture entries with occupancy count.
module capture_fifo import dsp_capture_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  cap_entry_t din,
  output cap_entry_t dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  cap_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  // a push into a full FIFO is only accepted when the head leaves on the same edge
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/dsp_result_capture.sv
// dsp_result_capture: tracks DSP slice latency, captures/rounds/saturates P into a credited FIFO.
// DSP_CAPTURE_ROUND_EN (in dsp_capture_pkg) enables round-half-up instead of floor.
module dsp_result_capture import dsp_capture_pkg::*; #(
  parameter int LATENCY = DEF_LATENCY,
  parameter int SHIFT = DEF_SHIFT,
  parameter int OUT_W = DEF_OUT_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic in_issue,
  output logic issue_ready,
  input  logic [P_W-1:0] p,
  input  logic carry_out,
  output logic out_valid,
  input  logic out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic out_carry,
  output logic out_sat,
  output logic overflow_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [LATENCY-1:0] tok;
  logic [LATENCY:0] tok_sh;
  logic [CW-1:0] count;
  logic cap, pop, full, empty;
  int in_flight;
  cap_entry_t din, head;
  assign tok_sh = {tok, in_issue};
  assign cap = tok[LATENCY-1];
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  always_comb begin
    din = round_sat(p, SHIFT, OUT_W);
    din.carry = carry_out;
  end
  always_comb begin
    in_flight = 0;
    for (int i = 0; i < LATENCY; i++) in_flight += int'(tok[i]);
  end
  // credit counts tokens still in the pipe so every issued result has a slot
  assign issue_ready = int'(count) + in_flight < DEPTH;
  always_ff @(posedge clk) begin
    if (rst) begin
      tok <= '0;
      overflow_err <= 1'b0;
    end else begin
      tok <= tok_sh[LATENCY-1:0];
      if (cap && full && !pop) overflow_err <= 1'b1;
    end
  end
  capture_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(cap),
    .pop(pop),
    .din(din),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign out_data = head.data[OUT_W-1:0];
  assign out_carry = head.carry;
  assign out_sat = head.sat;
endmodule

// File: tb/tb_dsp_result_capture.sv
// tb_dsp_result_capture: table-driven vectors plus credit/overflow/reset sequences.
module tb_dsp_result_capture;
`ifdef DSP_CAPTURE_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  typedef struct {
    logic [47:0] p;
    logic c;
    logic [23:0] d;
    logic s;
  } vec_t;
  logic clk, rst, in_issue, issue_ready, carry_out, out_valid, out_ready;
  logic out_carry, out_sat, overflow_err;
  logic [47:0] p;
  logic [23:0] out_data;
  logic [31:0] ir, ov, vl;
  logic [23:0] got[$];
  int tests = 0, fails = 0, nis;
  vec_t v[11];
  dsp_result_capture dut (
    .clk(clk), .rst(rst), .in_issue(in_issue), .issue_ready(issue_ready),
    .p(p), .carry_out(carry_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_carry(out_carry), .out_sat(out_sat),
    .overflow_err(overflow_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic run(input int n, input logic [31:0] iss, input logic [31:0] rdy, input bit gate, input int rst_at);
    got.delete();
    nis = 0;
    for (int c = 0; c < n; c++) begin
      in_issue = iss[c] && (!gate || issue_ready);
      out_ready = rdy[c];
      rst = (c == rst_at);
      p = 48'(c + 1) << 12;
      carry_out = 1'b0;
      ir[c] = issue_ready;
      ov[c] = overflow_err;
      vl[c] = out_valid;
      nis += int'(in_issue);
      if (out_valid && out_ready) got.push_back(out_data);
      step();
    end
    in_issue = 1'b0;
    out_ready = 1'b0;
    rst = 1'b0;
  endtask
  initial begin
    v[0]  = '{48'h0000_0000_1800, 1'b0, RND ? 24'd2 : 24'd1, 1'b0};
    v[1]  = '{48'hFFFF_FFFF_E800, 1'b1, RND ? 24'hFFFFFF : 24'hFFFFFE, 1'b0};
    v[2]  = '{48'h7FFF_FFFF_FFFF, 1'b0, 24'h7FFFFF, 1'b1};
    v[3]  = '{48'h8000_0000_0000, 1'b1, 24'h800000, 1'b1};
    v[4]  = '{48'h0, 1'b0, 24'h0, 1'b0};
    v[5]  = '{48'h0007_FFFF_F000, 1'b1, 24'h7FFFFF, 1'b0};
    v[6]  = '{48'h0007_FFFF_F800, 1'b0, 24'h7FFFFF, RND};
    v[7]  = '{48'hFFF8_0000_0000, 1'b0, 24'h800000, 1'b0};
    v[8]  = '{48'hFFF7_FFFF_FFFF, 1'b1, 24'h800000, !RND};
    v[9]  = '{48'h0000_0000_0800, 1'b0, RND ? 24'd1 : 24'd0, 1'b0};
    v[10] = '{48'h0000_0000_0FFF, 1'b1, RND ? 24'd1 : 24'd0, 1'b0};
    in_issue = 1'b0;
    out_ready = 1'b0;
    p = '0;
    carry_out = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_carry", out_carry, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_ready", issue_ready, 1);
    rst = 1'b0;
    for (int k = 0; k < 11; k++) begin
      in_issue = 1'b1;
      step();
      in_issue = 1'b0;
      step();
      step();
      step();
      chk($sformatf("vec%0d_early", k), out_valid, 0);
      p = v[k].p;
      carry_out = v[k].c;
      step();
      p = '0;
      carry_out = 1'b0;
      chk($sformatf("vec%0d_valid", k), out_valid, 1);
      chk($sformatf("vec%0d_data", k), out_data, v[k].d);
      chk($sformatf("vec%0d_sat", k), out_sat, v[k].s);
      chk($sformatf("vec%0d_carry", k), out_carry, v[k].c);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk($sformatf("vec%0d_popped", k), out_valid, 0);
    end
    do_reset();
    run(14, 32'hFF, 32'hFFFFFF00, 1'b1, -1);
    chk("bp_issues", nis, 4);
    chk("bp_ready3", ir[3], 1);
    chk("bp_ready4", ir[4], 0);
    chk("bp_ready7", ir[7], 0);
    chk("bp_ready12", ir[12], 1);
    chk("bp_count", got.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("bp_out%0d", i), got[i], 24'(i + 5));
    chk("bp_ovf", ov[13], 0);
    do_reset();
    run(16, 32'h1F, 32'hFFFFFF00, 1'b0, -1);
    chk("fpp_ready4", ir[4], 0);
    chk("fpp_count", got.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("fpp_out%0d", i), got[i], 24'(i + 5));
    chk("fpp_empty", vl[13], 0);
    chk("fpp_ovf", ov[15], 0);
    do_reset();
    run(18, 32'h1F, 32'hFFFFFC00, 1'b0, -1);
    chk("ovf_before", ov[8], 0);
    chk("ovf_set", ov[9], 1);
    chk("ovf_sticky", ov[17], 1);
    chk("ovf_count", got.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("ovf_out%0d", i), got[i], 24'(i + 5));
    do_reset();
    chk("ovf_cleared", overflow_err, 0);
    run(20, 32'h19, 32'hFFFFFF80, 1'b0, 5);
    chk("rmo_stored", vl[5], 1);
    chk("rmo_valid", vl[6], 0);
    chk("rmo_ready", ir[6], 1);
    chk("rmo_ovf", ov[6], 0);
    chk("rmo_none", got.size(), 0);
    chk("rmo_quiet", vl[19:7], 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
